// File: rtl/bekletmeli_aritmetik_birim.sv
// Multicycle ALU for the YURUTGERIYAZ stage: iterative shifter, optional extra wait
// cycles, and a combinational stage-advance qualifier (ilerle_o).
module bekletmeli_aritmetik_birim #(
   parameter int VERI_BIT      = 32,
   parameter int EK_GECIKME    = 0,
   parameter int KAYDIRMA_ADIM = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                basla_i,
   input  logic [2:0]          funct3_i,
   input  logic                alt_i,
   input  logic [VERI_BIT-1:0] islenen1_i,
   input  logic [VERI_BIT-1:0] islenen2_i,
   output logic [VERI_BIT-1:0] sonuc_o,
   output logic                sonuc_gecerli_o,
   output logic                mesgul_o,
   output logic                ilerle_o
);

   localparam int SH_W = $clog2(VERI_BIT);
   localparam int KW   = SH_W + 1;
   localparam logic [KW-1:0] ADIM = KW'(KAYDIRMA_ADIM);
   localparam logic [3:0]    EK   = 4'(EK_GECIKME);

   typedef enum logic [1:0] {BOSTA, HESAPLA, BEKLE, BITTI} durum_t;

   durum_t              durum_q, durum_d;
   logic [VERI_BIT-1:0] a_q, a_d;
   logic [VERI_BIT-1:0] b_q, b_d;
   logic [VERI_BIT-1:0] sonuc_q, sonuc_d;
   logic [2:0]          funct3_q, funct3_d;
   logic                alt_q, alt_d;
   logic [KW-1:0]       kalan_q, kalan_d;
   logic [3:0]          sayac_q, sayac_d;

   logic                kaydirma;
   logic [KW-1:0]       adim;
   logic [VERI_BIT-1:0] hesap;

   // a_q doubles as the shifter's working register and as the staging slot
   // for the result while BEKLE runs out.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
      kaydirma = (funct3_q == 3'b001) || (funct3_q == 3'b101);
      adim     = (kalan_q < ADIM) ? kalan_q : ADIM;
      hesap    = '0;
      case (funct3_q)
         3'b000: begin
            if (alt_q) hesap = a_q - b_q;
            else       hesap = a_q + b_q;
         end
         3'b001: hesap    = a_q << adim;
         3'b010: hesap[0] = $signed(a_q) < $signed(b_q);
         3'b011: hesap[0] = a_q < b_q;
         3'b100: hesap    = a_q ^ b_q;
         3'b101: begin
            if (alt_q) hesap = $signed(a_q) >>> adim;
            else       hesap = a_q >> adim;
         end
         3'b110: hesap = a_q | b_q;
         3'b111: hesap = a_q & b_q;
         default: hesap = '0;
      endcase
   end

   always_comb begin
      durum_d  = durum_q;
      a_d      = a_q;
      b_d      = b_q;
      sonuc_d  = sonuc_q;
      funct3_d = funct3_q;
      alt_d    = alt_q;
      kalan_d  = kalan_q;
      sayac_d  = sayac_q;
      case (durum_q)
         BOSTA, BITTI: begin
            durum_d = BOSTA;
            if (basla_i) begin
               a_d      = islenen1_i;
               b_d      = islenen2_i;
               funct3_d = funct3_i;
               alt_d    = alt_i;
               kalan_d  = KW'(islenen2_i[SH_W-1:0]);
               durum_d  = HESAPLA;
            end
         end
         HESAPLA: begin
            a_d     = hesap;
            kalan_d = kalan_q - adim;
            if (!kaydirma || (kalan_q <= ADIM)) begin
               if (EK != 4'd0) begin
                  sayac_d = EK;
                  durum_d = BEKLE;
               end else begin
                  sonuc_d = hesap;
                  durum_d = BITTI;
               end
            end
         end
         BEKLE: begin
            sayac_d = sayac_q - 4'd1;
            if (sayac_q == 4'd1) begin
               sonuc_d = a_q;
               durum_d = BITTI;
            end
         end
         default: durum_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         durum_q  <= BOSTA;
         a_q      <= '0;
         b_q      <= '0;
         sonuc_q  <= '0;
         funct3_q <= '0;
         alt_q    <= 1'b0;
         kalan_q  <= '0;
         sayac_q  <= '0;
      end else begin
         durum_q  <= durum_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sonuc_q  <= sonuc_d;
         funct3_q <= funct3_d;
         alt_q    <= alt_d;
         kalan_q  <= kalan_d;
         sayac_q  <= sayac_d;
      end
   end

   assign sonuc_o         = sonuc_q;
   assign sonuc_gecerli_o = (durum_q == BITTI);
   assign mesgul_o        = (durum_q == HESAPLA) || (durum_q == BEKLE);
   assign ilerle_o        = (durum_q == BITTI) || ((durum_q == BOSTA) && !basla_i);

endmodule
